// File: rtl/regfile_scoreboard_if.sv
// Read/write/issue bundle for the register file with busy scoreboard.
// Latency: none; every signal is a plain wire between producer and register file.
// Backpressure: none; the hazard unit stalls on the BusyA/BusyB outputs instead.
// Ports: RA/RB read addresses, BusA/BusB read data, BusyA/BusyB hazard flags,
//        RW/BusW/RegWr write port (RegWr also retires busy), IssueRd/IssueEn busy set.
interface regfile_scoreboard_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic [ADDR_BITS-1:0] RA;
  logic [ADDR_BITS-1:0] RB;
  logic [WIDTH-1:0]     BusA;
  logic [WIDTH-1:0]     BusB;
  logic                 BusyA;
  logic                 BusyB;
  logic [ADDR_BITS-1:0] RW;
  logic [WIDTH-1:0]     BusW;
  logic                 RegWr;
  logic [ADDR_BITS-1:0] IssueRd;
  logic                 IssueEn;

  // Pipeline side: drives addresses, write data and issue requests.
  modport master (
    output RA, RB, RW, BusW, RegWr, IssueRd, IssueEn,
    input  BusA, BusB, BusyA, BusyB
  );

  // Register file side.
  modport slave (
    input  RA, RB, RW, BusW, RegWr, IssueRd, IssueEn,
    output BusA, BusB, BusyA, BusyB
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass and per-register busy scoreboard.
// Latency: reads combinational; writes and busy updates land on the rising edge of Clk.
// Backpressure: none; BusyA/BusyB tell the hazard unit when a source awaits an in-flight write.
// Ports: Clk, Reset (synchronous, active-high, clears data and busy), rf = slave side of
//        regfile_scoreboard_if (read ports A/B, write port, issue port).
module regfile_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile_scoreboard_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // True when the address is the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_BITS-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Effective write: writes aimed at the hardwired zero register are dropped,
  // so wr_hit(X) reduces to wr_eff && RW == X.
  logic wr_eff;
  logic set_eff;
  assign wr_eff  = rf.RegWr && !is_zero_reg(rf.RW);
  assign set_eff = rf.IssueEn && !is_zero_reg(rf.IssueRd);

  // Next-state for storage and scoreboard.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_eff) begin
      regs_d[rf.RW] = rf.BusW;
      busy_d[rf.RW] = 1'b0;
    end
    // Applied after the retire so a producer issued in the same cycle as the
    // old producer retires leaves the register busy.
    if (set_eff) begin
      busy_d[rf.IssueRd] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port A.
  logic             hit_a;
  logic [WIDTH-1:0] bus_a;
  logic             busy_a;

  always_comb begin
    hit_a = wr_eff && (rf.RW == rf.RA);
    if (is_zero_reg(rf.RA)) begin
      bus_a = '0;
    end else if ((BYPASS != 0) && hit_a) begin
      bus_a = rf.BusW;
    end else begin
      bus_a = regs_q[rf.RA];
    end
    // With bypass the retiring write already delivers the value, so no stall.
    busy_a = busy_q[rf.RA] && !((BYPASS != 0) && hit_a);
  end

  // Read port B.
  logic             hit_b;
  logic [WIDTH-1:0] bus_b;
  logic             busy_b;

  always_comb begin
    hit_b = wr_eff && (rf.RW == rf.RB);
    if (is_zero_reg(rf.RB)) begin
      bus_b = '0;
    end else if ((BYPASS != 0) && hit_b) begin
      bus_b = rf.BusW;
    end else begin
      bus_b = regs_q[rf.RB];
    end
    busy_b = busy_q[rf.RB] && !((BYPASS != 0) && hit_b);
  end

  assign rf.BusA  = bus_a;
  assign rf.BusB  = bus_b;
  assign rf.BusyA = busy_a;
  assign rf.BusyB = busy_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (zero-reg+bypass, and neither) driven in lockstep.
// Stimulus queues expected read results tagged with the cycle; a monitor checks them on negedge.
module tb_regfile_scoreboard;

  logic Clk;
  logic Reset;
  int   cyc;
  int   total;
  int   bad;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  regfile_scoreboard_if #(.WIDTH(32), .ADDR_BITS(5)) if0 ();
  regfile_scoreboard_if #(.WIDTH(32), .ADDR_BITS(5)) if1 ();

  regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) u_dut_zb (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (if0.slave)
  );

  regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(0)) u_dut_plain (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (if1.slave)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  task automatic expect_out(input string nm, input int dut, input logic [31:0] a,
                            input logic [31:0] b, input logic ba, input logic bb);
    exp_t e;
    e.cyc = cyc;
    e.dut = dut;
    e.a   = a;
    e.b   = b;
    e.ba  = ba;
    e.bb  = bb;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_both(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic ba, input logic bb);
    expect_out(nm, 0, a, b, ba, bb);
    expect_out(nm, 1, a, b, ba, bb);
  endtask

  task automatic drive(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic [31:0] w, input logic we,
                       input logic [4:0] ird, input logic ien);
    Reset       = rst;
    if0.RA      = ra;  if1.RA      = ra;
    if0.RB      = rb;  if1.RB      = rb;
    if0.RW      = rw;  if1.RW      = rw;
    if0.BusW    = w;   if1.BusW    = w;
    if0.RegWr   = we;  if1.RegWr   = we;
    if0.IssueRd = ird; if1.IssueRd = ird;
    if0.IssueEn = ien; if1.IssueEn = ien;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: checks every expectation queued for the current cycle.
  initial begin
    exp_t        e;
    string       nm;
    logic [31:0] act_a;
    logic [31:0] act_b;
    logic        act_ba;
    logic        act_bb;
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (e.dut == 0) begin
          act_a = if0.BusA; act_b = if0.BusB; act_ba = if0.BusyA; act_bb = if0.BusyB;
        end else begin
          act_a = if1.BusA; act_b = if1.BusB; act_ba = if1.BusyA; act_bb = if1.BusyB;
        end
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %s dut%0d: check missed, queued cyc=%0d now cyc=%0d", nm, e.dut, e.cyc, cyc);
        end else if (act_a !== e.a || act_b !== e.b || act_ba !== e.ba || act_bb !== e.bb) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d: got A=%h B=%h BusyA=%b BusyB=%b, want A=%h B=%h BusyA=%b BusyB=%b",
                   nm, e.dut, cyc, act_a, act_b, act_ba, act_bb, e.a, e.b, e.ba, e.bb);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;

    // Reset edge, then hold reset for one observed cycle.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    step();
    expect_both("rst_hold", 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // Every address on both ports reads zero and not busy.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      expect_both("rst_read", 32'h0, 32'h0, 1'b0, 1'b0);
      step();
    end

    // r5 write with same-cycle read: bypassed vs stored value.
    drive(1'b0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0);
    expect_out("wr5_bypass", 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_out("wr5_old",    1, 32'h0,        32'h0,        1'b0, 1'b0);
    step();
    drive(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("wr5_after", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    step();

    // r0 write + issue: hardwired zero vs ordinary register.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1);
    expect_both("r0_wr_cyc", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_out("r0_zero",  0, 32'h0,        32'h0,        1'b0, 1'b0);
    expect_out("r0_plain", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    step();
    expect_out("r0_zero_later", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // Issue r7, hold busy for three cycles, then retire with 0x42.
    drive(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1);
    expect_both("r7_issue_cyc", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      expect_both("r7_busy", 32'h0, 32'h0, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 5'd7, 5'd7, 5'd7, 32'h42, 1'b1, 5'd0, 1'b0);
    expect_out("r7_retire_bypass", 0, 32'h42, 32'h42, 1'b0, 1'b0);
    expect_out("r7_retire_plain",  1, 32'h0,  32'h0,  1'b1, 1'b1);
    step();
    drive(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("r7_after", 32'h42, 32'h42, 1'b0, 1'b0);
    step();

    // Same-edge issue and retire on r9: set wins.
    drive(1'b0, 5'd9, 5'd9, 5'd9, 32'h99, 1'b1, 5'd9, 1'b1);
    expect_out("r9_same_bypass", 0, 32'h99, 32'h99, 1'b0, 1'b0);
    expect_out("r9_same_plain",  1, 32'h0,  32'h0,  1'b0, 1'b0);
    step();
    drive(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("r9_after", 32'h99, 32'h99, 1'b1, 1'b1);
    step();

    // Busy r3 and r12, retire r3, then reset colliding with a write to r12.
    drive(1'b0, 5'd3, 5'd12, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1);
    expect_both("r3_issue_cyc", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd3, 5'd12, 5'd0, 32'h0, 1'b0, 5'd12, 1'b1);
    expect_both("r12_issue_cyc", 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 5'd3, 5'd12, 5'd3, 32'h11, 1'b1, 5'd0, 1'b0);
    expect_out("r3_retire_bypass", 0, 32'h11, 32'h0, 1'b0, 1'b1);
    expect_out("r3_retire_plain",  1, 32'h0,  32'h0, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd3, 5'd3, 5'd12, 32'h1234, 1'b1, 5'd20, 1'b1);
    expect_both("pre_reset_r3", 32'h11, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd12, 5'd3, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("post_rst_r12_r3", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd20, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("post_rst_r20_r5", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_both("post_rst_r9_r0", 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // Drain: anything left unchecked after a bounded wait is a failure.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      step();
    end
    if (exp_q.size() > 0) begin
      total += exp_q.size();
      bad   += exp_q.size();
      $display("FAIL drain: %0d checks left unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
